w_fetch_unit: RTL and testbench

Weight-tile fetch stage feeding the systolic array's weight shift chain, driven by the weight-side control handshake (`w_read`, `clr_w`, `w_done`). On each load request it reads one tile of ROWS weight words from weight SRAM, which has a fixed 1-cycle read latency. It forwards the words into the array weight shadow registers, then returns a one-cycle `w_done` to the controller. It keeps a tile pointer that advances per tile and wraps after a configured tile count.

---
 rtl/w_fetch_unit.sv | 136 +++++++++++++
 tb/tb_w_fetch_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/w_fetch_unit.sv
// w_fetch_unit: reads one ROWS-word weight tile from 1-cycle-latency SRAM
// and streams it into the systolic array weight chain. A tile pointer
// advances by ROWS per completed tile and wraps back to the base address
// after a configurable number of tiles.
module w_fetch_unit #(
  parameter int ROWS   = 8,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_w_read,
  input  logic                     i_clr_w,
  input  logic [ADDR_W-1:0]        i_cfg_base,
  input  logic [7:0]               i_cfg_tiles,
  output logic                     o_mem_rd_en,
  output logic [ADDR_W-1:0]        o_mem_addr,
  input  logic [ROWS*DATA_W-1:0]   i_mem_rdata,
  output logic                     o_w_shift_en,
  output logic [ROWS*DATA_W-1:0]   o_w_data,
  output logic                     o_w_done,
  output logic                     o_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_LAST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int               CNT_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(ROWS);

  state_t              r_state;
  state_t              w_next_state;
  logic [CNT_W-1:0]    r_row_cnt;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [7:0]          r_tile_idx;
  logic                r_shift_en_p1;
  logic [7:0]          w_last_idx;
  logic                w_last_row;

  // cfg_tiles of 0 wraps naturally to 255 in 8-bit arithmetic, i.e. 256 tiles.
  assign w_last_idx = i_cfg_tiles - 8'd1;
  assign w_last_row = (r_row_cnt == LAST_ROW);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; a clear aborts any tile, but a clear together with a
  // request in IDLE still starts the tile (from the freshly loaded base).
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (i_w_read) w_next_state = S_FETCH;
      S_FETCH: if (w_last_row) w_next_state = S_LAST;
      S_LAST:  w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
    if (i_clr_w && (r_state != S_IDLE)) begin
      w_next_state = S_IDLE;
    end
  end

  // Moore outputs decoded from the current state
  always_comb begin
    o_mem_rd_en = (r_state == S_FETCH);
    o_w_done    = (r_state == S_DONE);
    o_busy      = (r_state != S_IDLE);
  end

  // Pointer, tile counter, row counter and read address bookkeeping
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr         <= '0;
      r_base        <= '0;
      r_tile_idx    <= '0;
      r_row_cnt     <= '0;
      r_mem_addr    <= '0;
      r_shift_en_p1 <= 1'b0;
    end else begin
      // Read data returns one cycle after the read; a clear cancels the
      // shift of the word still in flight.
      r_shift_en_p1 <= o_mem_rd_en && !i_clr_w;
      if (i_clr_w) begin
        r_base     <= i_cfg_base;
        r_ptr      <= i_cfg_base;
        r_tile_idx <= '0;
        r_row_cnt  <= '0;
        if ((r_state == S_IDLE) && i_w_read) begin
          r_mem_addr <= i_cfg_base;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            r_row_cnt <= '0;
            if (i_w_read) r_mem_addr <= r_ptr;
          end
          S_FETCH: begin
            // Address holds at the last row so it stays stable outside FETCH.
            if (!w_last_row) begin
              r_row_cnt  <= r_row_cnt + CNT_W'(1);
              r_mem_addr <= r_mem_addr + ADDR_W'(1);
            end
          end
          S_DONE: begin
            if (r_tile_idx == w_last_idx) begin
              r_ptr      <= r_base;
              r_tile_idx <= '0;
            end else begin
              r_ptr      <= r_ptr + ROW_STEP;
              r_tile_idx <= r_tile_idx + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_mem_addr   = r_mem_addr;
  assign o_w_shift_en = r_shift_en_p1;
  assign o_w_data     = i_mem_rdata;

endmodule

// File: tb/tb_w_fetch_unit.sv
// Directed testbench for w_fetch_unit with ROWS=4, DATA_W=8, ADDR_W=16.
module tb_w_fetch_unit;

  localparam int ROWS   = 4;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 16;

  logic                   i_clk = 1'b0;
  logic                   i_rst;
  logic                   i_w_read;
  logic                   i_clr_w;
  logic [ADDR_W-1:0]      i_cfg_base;
  logic [7:0]             i_cfg_tiles;
  logic                   o_mem_rd_en;
  logic [ADDR_W-1:0]      o_mem_addr;
  logic [ROWS*DATA_W-1:0] i_mem_rdata;
  logic                   o_w_shift_en;
  logic [ROWS*DATA_W-1:0] o_w_data;
  logic                   o_w_done;
  logic                   o_busy;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  w_fetch_unit #(.ROWS(ROWS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_w_read(i_w_read), .i_clr_w(i_clr_w),
    .i_cfg_base(i_cfg_base), .i_cfg_tiles(i_cfg_tiles),
    .o_mem_rd_en(o_mem_rd_en), .o_mem_addr(o_mem_addr), .i_mem_rdata(i_mem_rdata),
    .o_w_shift_en(o_w_shift_en), .o_w_data(o_w_data), .o_w_done(o_w_done),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  // SRAM contents are a fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a[7:0] ^ 8'h5A, a[15:8], ~a[7:0], a[7:0] + 8'd3};
  endfunction

  // 1-cycle read latency SRAM model
  always @(posedge i_clk) begin
    if (o_mem_rd_en) i_mem_rdata <= mem_word(o_mem_addr);
  end

  always @(posedge i_clk) begin
    if (o_w_done) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rd"}, {31'd0, o_mem_rd_en}, 32'd0);
    chk({tag, "_sh"}, {31'd0, o_w_shift_en}, 32'd0);
    chk({tag, "_done"}, {31'd0, o_w_done}, 32'd0);
    chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
  endtask

  // Pulses w_read, then checks cycles 1..6 of the tile; wr_mask[c] holds
  // w_read high during cycle c to exercise ignored requests.
  task automatic run_tile(input string tag, input logic [15:0] base, input logic [7:0] wr_mask);
    logic [15:0] a;
    logic        e_rd, e_sh, e_done;
    int          d0;
    d0 = done_cnt;
    i_w_read = 1'b1;
    tick();
    for (int c = 1; c <= 6; c++) begin
      e_rd   = (c >= 1 && c <= 4);
      e_sh   = (c >= 2 && c <= 5);
      e_done = (c == 6);
      chk($sformatf("%s_c%0d_rd", tag, c), {31'd0, o_mem_rd_en}, {31'd0, e_rd});
      chk($sformatf("%s_c%0d_sh", tag, c), {31'd0, o_w_shift_en}, {31'd0, e_sh});
      chk($sformatf("%s_c%0d_done", tag, c), {31'd0, o_w_done}, {31'd0, e_done});
      chk($sformatf("%s_c%0d_busy", tag, c), {31'd0, o_busy}, 32'd1);
      if (e_rd) begin
        a = base + 16'(c - 1);
        chk($sformatf("%s_c%0d_addr", tag, c), {16'd0, o_mem_addr}, {16'd0, a});
      end
      if (e_sh) begin
        a = base + 16'(c - 2);
        chk($sformatf("%s_c%0d_data", tag, c), o_w_data, mem_word(a));
      end
      i_w_read = wr_mask[c];
      tick();
    end
    i_w_read = 1'b0;
    chk({tag, "_one_done"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_end_busy"}, {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    int d0;
    i_rst = 1'b1; i_w_read = 1'b0; i_clr_w = 1'b0;
    i_cfg_base = 16'h0000; i_cfg_tiles = 8'd3;
    tick(); tick(); tick();
    chk_idle("reset");
    chk("reset_addr", {16'd0, o_mem_addr}, 32'd0);
    i_rst = 1'b0;
    tick();

    // Load base 0x0100, then four tiles with wrap after 3
    i_cfg_base = 16'h0100; i_clr_w = 1'b1;
    tick();
    i_clr_w = 1'b0;
    chk_idle("after_clr");
    d0 = done_cnt;
    run_tile("t0", 16'h0100, 8'h00);
    run_tile("t1", 16'h0104, 8'h00);
    run_tile("t2", 16'h0108, 8'h00);
    run_tile("t3", 16'h0100, 8'h00);
    chk("four_tiles_done", 32'(done_cnt - d0), 32'd4);

    // Address wrap-around across 0xFFFF, 256-tile wrap count
    i_cfg_base = 16'hFFFE; i_cfg_tiles = 8'd0; i_clr_w = 1'b1;
    tick();
    i_clr_w = 1'b0;
    run_tile("wrapA", 16'hFFFE, 8'h00);
    run_tile("wrapB", 16'h0002, 8'h00);

    // Abort with clr_w in cycle 3
    d0 = done_cnt;
    i_w_read = 1'b1;
    tick();
    i_w_read = 1'b0;
    chk("ab_c1_addr", {16'd0, o_mem_addr}, 32'h0006);
    tick();
    chk("ab_c2_sh", {31'd0, o_w_shift_en}, 32'd1);
    tick();
    chk("ab_c3_rd", {31'd0, o_mem_rd_en}, 32'd1);
    i_cfg_base = 16'h0200; i_clr_w = 1'b1;
    tick();
    i_clr_w = 1'b0;
    chk_idle("ab_c4");
    tick(); tick(); tick();
    chk_idle("ab_c7");
    chk("ab_no_done", 32'(done_cnt - d0), 32'd0);
    run_tile("ab_next", 16'h0200, 8'h00);

    // w_read pulses in FETCH (c2), LAST (c5) and DONE (c6) are ignored
    d0 = done_cnt;
    run_tile("ign", 16'h0204, 8'b0110_0100);
    tick(); tick();
    chk_idle("ign_after");
    chk("ign_total", 32'(done_cnt - d0), 32'd1);

    // Simultaneous clr_w + w_read in IDLE, then rst mid-tile
    d0 = done_cnt;
    i_cfg_base = 16'h0300; i_clr_w = 1'b1; i_w_read = 1'b1;
    tick();
    i_clr_w = 1'b0; i_w_read = 1'b0;
    chk("sim_c1_rd", {31'd0, o_mem_rd_en}, 32'd1);
    chk("sim_c1_addr", {16'd0, o_mem_addr}, 32'h0300);
    tick();
    chk("sim_c2_addr", {16'd0, o_mem_addr}, 32'h0301);
    chk("sim_c2_data", o_w_data, mem_word(16'h0300));
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk_idle("rst_c3");
    chk("rst_c3_addr", {16'd0, o_mem_addr}, 32'd0);
    tick(); tick(); tick(); tick();
    chk("rst_no_done", 32'(done_cnt - d0), 32'd0);
    // Pointer reset to 0: next tile reads from address 0
    i_cfg_tiles = 8'd0;
    run_tile("post_rst", 16'h0000, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
